// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory access sizes, LSU state encoding and bus payload.
package cpu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned BE_W   = XLEN / 8;
    localparam int unsigned CNT_W  = 8;

    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic              we;
        logic [XLEN-1:0]   addr;
        logic [BE_W-1:0]   be;
        logic [XLEN-1:0]   wdata;
    } bus_cmd_t;

    // Size 2'b11 falls into the word case.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            MEM_B:   return 1'b0;
            MEM_H:   return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for stores (byte enables, replicated data) and lane select plus
// sign/zero extension for loads.
module lsu_align
    import cpu_pkg::*;
(
    input  logic [1:0]      size_i,
    input  logic [1:0]      off_i,
    input  logic            uns_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [BE_W-1:0] be_c_o,
    output logic [XLEN-1:0] wdata_c_o,
    output logic [XLEN-1:0] ldata_c_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        sign_bit;

    always_comb begin
        byte_lane = rdata_i[{off_i, 3'b000} +: 8];
        half_lane = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        sign_bit  = 1'b0;
        be_c_o    = 4'b1111;
        wdata_c_o = wdata_i;
        ldata_c_o = rdata_i;
        case (size_i)
            MEM_B: begin
                sign_bit  = ~uns_i & byte_lane[7];
                be_c_o    = 4'b0001 << off_i;
                wdata_c_o = {4{wdata_i[7:0]}};
                ldata_c_o = {{24{sign_bit}}, byte_lane};
            end
            MEM_H: begin
                sign_bit  = ~uns_i & half_lane[15];
                be_c_o    = 4'b0011 << {off_i[1], 1'b0};
                wdata_c_o = {2{wdata_i[15:0]}};
                ldata_c_o = {{16{sign_bit}}, half_lane};
            end
            default: begin
                be_c_o    = 4'b1111;
                wdata_c_o = wdata_i;
                ldata_c_o = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding access, bus request/grant/rvalid handshake,
// alignment checks and a bus-wait timeout.
module load_store_unit
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [1:0]      mem_size,
    input  logic            mem_unsigned,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] load_data,
    output logic            resp_misalign,
    output logic            resp_err,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [BE_W-1:0] bus_be,
    output logic [XLEN-1:0] bus_wdata,
    input  logic            bus_gnt,
    input  logic            bus_rvalid,
    input  logic [XLEN-1:0] bus_rdata
);

    lsu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             timeout_c;
    logic [1:0]       size_q;
    logic [1:0]       off_q;
    logic             uns_q;
    logic             req_ready_q;
    logic             resp_valid_q;
    logic             resp_mis_q;
    logic             resp_err_q;
    logic [XLEN-1:0]  load_data_q;
    bus_cmd_t         bus_cmd_q;
    logic             bus_req_q;

    logic [1:0]       al_size;
    logic [1:0]       al_off;
    logic             al_uns;
    logic [BE_W-1:0]  al_be_c;
    logic [XLEN-1:0]  al_wdata_c;
    logic [XLEN-1:0]  al_ldata_c;
    logic             is_access_c;
    logic             misalign_c;

    // Steering follows the live request while idle and the captured one afterwards.
    assign al_size = (state_q == ST_IDLE) ? mem_size     : size_q;
    assign al_off  = (state_q == ST_IDLE) ? addr[1:0]    : off_q;
    assign al_uns  = (state_q == ST_IDLE) ? mem_unsigned : uns_q;

    lsu_align u_align (
        .size_i    (al_size),
        .off_i     (al_off),
        .uns_i     (al_uns),
        .wdata_i   (wdata),
        .rdata_i   (bus_rdata),
        .be_c_o    (al_be_c),
        .wdata_c_o (al_wdata_c),
        .ldata_c_o (al_ldata_c)
    );

    always_comb begin
        cnt_d       = cnt_q + CNT_W'(1);
        timeout_c   = (9'({1'b0, cnt_q}) + 9'd1) == 9'(TIMEOUT_CYCLES);
        is_access_c = mem_read | mem_write;
        misalign_c  = is_misaligned(mem_size, addr[1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            size_q       <= MEM_B;
            off_q        <= 2'b00;
            uns_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_mis_q   <= 1'b0;
            resp_err_q   <= 1'b0;
            load_data_q  <= '0;
            bus_cmd_q    <= '0;
            bus_req_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        size_q      <= mem_size;
                        off_q       <= addr[1:0];
                        uns_q       <= mem_unsigned;
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        if (!is_access_c) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                        end else if (misalign_c) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_mis_q   <= 1'b1;
                        end else begin
                            // A request with both read and write set is a store.
                            state_q         <= ST_REQ;
                            bus_req_q       <= 1'b1;
                            bus_cmd_q.we    <= mem_write;
                            bus_cmd_q.addr  <= {addr[XLEN-1:2], 2'b00};
                            bus_cmd_q.be    <= al_be_c;
                            bus_cmd_q.wdata <= al_wdata_c;
                        end
                    end
                end
                ST_REQ: begin
                    cnt_q <= cnt_d;
                    if (timeout_c) begin
                        state_q      <= ST_RESP;
                        bus_req_q    <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                    end else if (bus_gnt) begin
                        bus_req_q <= 1'b0;
                        if (bus_cmd_q.we) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_d;
                    if (timeout_c) begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                    end else if (bus_rvalid) begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        load_data_q  <= al_ldata_c;
                    end
                end
                ST_RESP: begin
                    state_q      <= ST_IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_mis_q   <= 1'b0;
                    resp_err_q   <= 1'b0;
                    load_data_q  <= '0;
                    bus_cmd_q.we <= 1'b0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                    bus_req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign load_data     = load_data_q;
    assign resp_misalign = resp_mis_q;
    assign resp_err      = resp_err_q;
    assign bus_req       = bus_req_q;
    assign bus_we        = bus_cmd_q.we;
    assign bus_addr      = bus_cmd_q.addr;
    assign bus_be        = bus_cmd_q.be;
    assign bus_wdata     = bus_cmd_q.wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses, a configurable bus
// responder, and a monitor that checks bus commands and responses.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] load_data;
    logic        resp_misalign;
    logic        resp_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_size      (mem_size),
        .mem_unsigned  (mem_unsigned),
        .addr          (addr),
        .wdata         (wdata),
        .resp_valid    (resp_valid),
        .load_data     (load_data),
        .resp_misalign (resp_misalign),
        .resp_err      (resp_err),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_be        (bus_be),
        .bus_wdata     (bus_wdata),
        .bus_gnt       (bus_gnt),
        .bus_rvalid    (bus_rvalid),
        .bus_rdata     (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          chk_wd;
    } bus_exp_t;

    typedef struct {
        logic [31:0] data;
        logic        mis;
        logic        err;
        int          lat;
    } rsp_exp_t;

    bus_exp_t bus_q[$];
    rsp_exp_t rsp_q[$];

    int     n_cmp = 0;
    int     n_mis = 0;
    longint acc_t = 0;

    int          cfg_seq = 0;
    int          cfg_gnt_wait = 0;
    int          cfg_rv_wait = -1;
    bit          cfg_junk = 1'b0;
    logic [31:0] cfg_rdata = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Bus slave: grants after cfg_gnt_wait request cycles, returns read data
    // cfg_rv_wait+1 cycles after the grant (never if negative).
    int seq_seen = 0;
    int bph = 0;
    int bcnt = 0;
    always @(negedge clk) begin
        if (seq_seen != cfg_seq) begin
            seq_seen = cfg_seq;
            bph = 0;
            bcnt = 0;
        end
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'h5A5A5A5A;
        if (bph == 0 && bus_req) begin
            if (bcnt == cfg_gnt_wait) begin
                bus_gnt = 1'b1;
                if (cfg_junk) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = 32'hDEADBEEF;
                end
                bph  = 1;
                bcnt = 0;
            end else begin
                bcnt++;
            end
        end else if (bph == 1) begin
            if (cfg_rv_wait >= 0 && bcnt == cfg_rv_wait) begin
                bus_rvalid = 1'b1;
                bus_rdata  = cfg_rdata;
                bph = 2;
            end else begin
                bcnt++;
            end
        end
    end

    // Monitor: pops expectations when the DUT presents a bus command or a response.
    logic        bus_req_prev = 1'b0;
    logic [31:0] addr_hold = '0;
    rsp_exp_t    r;
    bus_exp_t    b;
    int          lat;
    always @(negedge clk) begin
        if (!rst_n) begin
            bus_req_prev = 1'b0;
        end else begin
            if (resp_valid) begin
                if (rsp_q.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL unexpected_resp: resp_valid=1 with nothing outstanding at %0t", $time);
                end else begin
                    r   = rsp_q.pop_front();
                    lat = int'(($time - acc_t - 5) / 10);
                    chk("load_data", load_data, r.data);
                    chk("resp_misalign", 32'(resp_misalign), 32'(r.mis));
                    chk("resp_err", 32'(resp_err), 32'(r.err));
                    chk("resp_latency", 32'(lat), 32'(r.lat));
                end
            end else begin
                chk("idle_load_data", load_data, 32'h0);
                chk("idle_flags", 32'({resp_misalign, resp_err}), 32'h0);
            end
            if (bus_req && !bus_req_prev) begin
                if (bus_q.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL unexpected_bus_req: bus_req=1 addr=%h with no access expected at %0t", bus_addr, $time);
                end else begin
                    b = bus_q.pop_front();
                    chk("bus_we", 32'(bus_we), 32'(b.we));
                    chk("bus_addr", bus_addr, b.addr);
                    chk("bus_be", 32'(bus_be), 32'(b.be));
                    if (b.chk_wd) chk("bus_wdata", bus_wdata, b.wdata);
                end
                addr_hold = bus_addr;
            end else if (bus_req) begin
                chk("bus_addr_stable", bus_addr, addr_hold);
            end
            if (bus_req) chk("req_ready_busy", 32'(req_ready), 32'h0);
            bus_req_prev = bus_req;
        end
    end

    task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int gw, input int rw, input bit junk, input logic [31:0] rdat,
                         input bit has_bus, input logic [31:0] eaddr, input logic [3:0] ebe,
                         input logic [31:0] ewd, input bit chkwd,
                         input logic [31:0] edata, input logic emis, input logic eerr, input int elat);
        bus_exp_t be_i;
        rsp_exp_t re_i;
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'h1);
        cfg_gnt_wait = gw;
        cfg_rv_wait  = rw;
        cfg_junk     = junk;
        cfg_rdata    = rdat;
        cfg_seq++;
        req_valid    = 1'b1;
        mem_read     = rd;
        mem_write    = wr;
        mem_size     = sz;
        mem_unsigned = uns;
        addr         = a;
        wdata        = wd;
        @(posedge clk);
        acc_t = $time;
        if (has_bus) begin
            be_i.we = wr; be_i.addr = eaddr; be_i.be = ebe; be_i.wdata = ewd; be_i.chk_wd = chkwd;
            bus_q.push_back(be_i);
        end
        re_i.data = edata; re_i.mis = emis; re_i.err = eerr; re_i.lat = elat;
        rsp_q.push_back(re_i);
        #1;
        req_valid    = 1'b0;
        mem_read     = 1'($urandom);
        mem_write    = 1'($urandom);
        mem_size     = 2'($urandom);
        mem_unsigned = 1'($urandom);
        addr         = $urandom;
        wdata        = $urandom;
    endtask

    task automatic wait_done(input int extra);
        int n;
        n = 0;
        while (rsp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("resp_outstanding", 32'(rsp_q.size()), 32'h0);
        chk("bus_outstanding", 32'(bus_q.size()), 32'h0);
        rsp_q.delete();
        bus_q.delete();
        repeat (extra) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        mem_size = 2'b00; mem_unsigned = 1'b0; addr = '0; wdata = '0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        #3;
        chk("rst_bus_req", 32'(bus_req), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_flags", 32'({bus_we, resp_misalign, resp_err}), 32'h0);
        chk("rst_bus_be", 32'(bus_be), 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_load_data", load_data, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(req_ready), 32'h1);

        // rd wr sz uns addr wdata | gw rw junk rdata | bus addr be wdata chkwd | data mis err lat
        issue(0, 1, 2'b00, 0, 32'h1003, 32'h000000AB, 0, -1, 0, 32'h0,
              1, 32'h1000, 4'b1000, 32'hABABABAB, 1, 32'h0, 0, 0, 1);
        wait_done(2);
        issue(1, 0, 2'b00, 0, 32'h2001, 32'h0, 0, 0, 0, 32'h0000F100,
              1, 32'h2000, 4'b0010, 32'h0, 0, 32'hFFFFFFF1, 0, 0, 2);
        wait_done(2);
        issue(1, 0, 2'b00, 1, 32'h2001, 32'h0, 0, 0, 0, 32'h0000F100,
              1, 32'h2000, 4'b0010, 32'h0, 0, 32'h000000F1, 0, 0, 2);
        wait_done(2);
        issue(1, 0, 2'b01, 0, 32'h2002, 32'h0, 0, 0, 0, 32'h80010000,
              1, 32'h2000, 4'b1100, 32'h0, 0, 32'hFFFF8001, 0, 0, 2);
        wait_done(2);
        issue(1, 0, 2'b01, 1, 32'h2002, 32'h0, 0, 0, 0, 32'h80010000,
              1, 32'h2000, 4'b1100, 32'h0, 0, 32'h00008001, 0, 0, 2);
        wait_done(2);
        issue(1, 0, 2'b10, 0, 32'h3002, 32'h0, 0, 0, 0, 32'h0,
              0, 32'h0, 4'b0000, 32'h0, 0, 32'h0, 1, 0, 0);
        wait_done(2);
        issue(0, 1, 2'b01, 0, 32'h4003, 32'h1234CDEF, 0, -1, 0, 32'h0,
              0, 32'h0, 4'b0000, 32'h0, 0, 32'h0, 1, 0, 0);
        wait_done(2);
        issue(0, 1, 2'b01, 0, 32'h4002, 32'h1234CDEF, 3, -1, 0, 32'h0,
              1, 32'h4000, 4'b1100, 32'hCDEFCDEF, 1, 32'h0, 0, 0, 4);
        wait_done(2);
        issue(1, 1, 2'b10, 0, 32'h5004, 32'hCAFEF00D, 0, -1, 0, 32'h0,
              1, 32'h5004, 4'b1111, 32'hCAFEF00D, 1, 32'h0, 0, 0, 1);
        wait_done(2);
        issue(1, 0, 2'b10, 0, 32'h6008, 32'h0, 0, 2, 1, 32'h89ABCDEF,
              1, 32'h6008, 4'b1111, 32'h0, 0, 32'h89ABCDEF, 0, 0, 4);
        wait_done(2);
        issue(1, 0, 2'b00, 0, 32'h7000, 32'h0, 1, 1, 0, 32'h12345680,
              1, 32'h7000, 4'b0001, 32'h0, 0, 32'hFFFFFF80, 0, 0, 4);
        wait_done(2);
        issue(1, 0, 2'b11, 0, 32'h700C, 32'h0, 0, 0, 0, 32'h0BADF00D,
              1, 32'h700C, 4'b1111, 32'h0, 0, 32'h0BADF00D, 0, 0, 2);
        wait_done(2);
        issue(0, 0, 2'b10, 0, 32'h8000, 32'h11111111, 0, 0, 0, 32'hFFFFFFFF,
              0, 32'h0, 4'b0000, 32'h0, 0, 32'h0, 0, 0, 0);
        wait_done(2);
        // Load timeout in WAIT; the late rvalid arrives after the unit is idle again.
        issue(1, 0, 2'b10, 0, 32'h9000, 32'h0, 1, 10, 0, 32'hFFFFFFFF,
              1, 32'h9000, 4'b1111, 32'h0, 0, 32'h0, 0, 1, 8);
        wait_done(12);
        // Store timeout while never granted.
        issue(0, 1, 2'b10, 0, 32'hA000, 32'h55AA55AA, 100, -1, 0, 32'h0,
              1, 32'hA000, 4'b1111, 32'h55AA55AA, 1, 32'h0, 0, 1, 8);
        wait_done(2);
        // Reset while waiting for read data abandons the access.
        issue(1, 0, 2'b10, 0, 32'hB000, 32'h0, 0, -1, 0, 32'h0,
              1, 32'hB000, 4'b1111, 32'h0, 0, 32'h0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstwait_bus_req", 32'(bus_req), 32'h0);
        chk("rstwait_resp_valid", 32'(resp_valid), 32'h0);
        chk("rstwait_req_ready", 32'(req_ready), 32'h1);
        rsp_q.delete();
        bus_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 32'(req_ready), 32'h1);
        issue(1, 0, 2'b00, 1, 32'hC002, 32'h0, 0, 0, 0, 32'h00A50000,
              1, 32'hC000, 4'b0100, 32'h0, 0, 32'h000000A5, 0, 0, 2);
        wait_done(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
